uart_result_tx: RTL and testbench
=================================

Name: uart_result_tx

Overview:
Transmit side of the image-processing UART link. It accepts byte-wide results from the systolic convolution engine, one byte per cycle of the valid strobe, and buffers them in a small FIFO. It serialises them onto the UART line as 8N1 frames, LSB first, at a fixed baud, and so closes the loop from the receive path through the systolic core back to the host.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 16, result buffer entries; power of two, 2..256
DATA_W, 8, result byte width; fixed at 8

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
res_data  in  8  result byte from systolic core
res_valid  in  1  res_data is written on every rising edge where this is high
tx  out  1  UART serial line; idle high
tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; set when a write is dropped

Behaviour:
- Reset (async assert, sync release): tx=1, tx_busy=0, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE, baud and bit counters=0, FIFO pointers=0.
- Reset mid-frame: the frame is abandoned immediately, tx returns to 1, and FIFO contents are discarded.
- Write:
  - res_valid high and FIFO not full: the byte is stored, and fifo_count increments on the same edge.
  - res_valid high with FIFO full and no pop that cycle: the byte is dropped, overflow sets to 1 and stays 1 until rst.
  - Full FIFO with a simultaneous pop: the write is accepted and the count is unchanged.
- Pop: occurs only in IDLE (FIFO non-empty) or on the final cycle of STOP (FIFO non-empty). The popped byte is loaded into the shift register.
- Simultaneous write and pop on an empty FIFO: not possible, because pop requires non-empty. The written byte waits one cycle.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1 and wraps; it restarts at 0 on every state entry.
  - IDLE: tx=1. If the FIFO is non-empty, pop and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle, pop and go to START if the FIFO is non-empty, otherwise go to IDLE.
- Latency: a byte written at edge k into an empty FIFO with the FSM in IDLE gets the pop at edge k+1. tx goes low after edge k+1 and stays low for CLKS_PER_BIT cycles.
- Back-to-back frames: there is no idle gap between frames; each frame is exactly 10*CLKS_PER_BIT cycles.
- Bit order: LSB first, 1 start bit, 8 data bits, 1 stop bit, no parity.
- tx is driven from a register; it is glitch-free and has no combinational path from the inputs.
- fifo_full and fifo_count are registered and reflect state after the current edge.
- Pointer wrap: the read and write pointers wrap modulo FIFO_DEPTH. Full and empty are derived from the count, not from pointer equality alone.
- Throughput: a sustained write rate above 1 byte per 10*CLKS_PER_BIT cycles eventually overflows. This is by design and is flagged via overflow.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - the default CLKS_PER_BIT;
  - the frame-length constant FRAME_BITS=10.
- One sub-module, sync_fifo (params DEPTH, W). It has write/read enables, registered count, full and empty flags, and the data output valid on the read edge.
- The top level holds the baud counter, the bit index, the shift register, the FSM and the overflow flag.

Test Plan:
- Single byte, 8'hA5, CLKS_PER_BIT=4, FIFO empty -> tx: 4 cycles of 0, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles of 1. tx_busy falls after the stop bit; overflow=0.
- Burst: 3 consecutive cycles of res_valid carrying 8'h02, 8'h01, 8'hFF -> three contiguous 40-cycle frames with no idle gap between them. fifo_count sequence reads 1,1,2 (pop overlapping the first writes), then drains to 0.
- Overflow: FIFO_DEPTH=4, CLKS_PER_BIT=4, 6 back-to-back writes of 8'h10..8'h15 -> 8'h10 is popped immediately, 8'h11..8'h14 fill the FIFO, 8'h15 is dropped and overflow=1. Transmitted bytes are 10,11,12,13,14, and overflow stays 1 afterwards.
- Full with simultaneous pop: FIFO full while the last STOP cycle coincides with a res_valid write -> the write is accepted, fifo_count is unchanged, and overflow stays 0.
- Reset mid-frame: assert rst during DATA bit 3 of 8'h3C with 2 bytes queued -> tx=1 asynchronously, fifo_count=0, tx_busy=0. After release, tx stays 1 with no residual frame.
- Idle line: no res_valid for 1000 cycles after reset -> tx=1 and tx_busy=0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the result-transmit UART: FSM encoding, default baud divisor, frame length.
package uart_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int FRAME_BITS           = 10;
endpackage

// File: rtl/uart_result_tx_if.sv
// Result-byte input bundle from the systolic core, plus the transmitter FSM state for observation.
// res_valid is a write strobe with no backpressure: every rising edge with res_valid high offers
// res_data once; there is no ready, so a write while the FIFO is full and not popping is dropped.
interface uart_result_tx_if;
  logic [7:0] res_data;
  logic       res_valid;
  logic [1:0] fsm_state;

  modport master (output res_data, output res_valid, input fsm_state);
  modport slave  (input res_data, input res_valid, output fsm_state);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full/empty come from the registered count, read data is valid on the read edge.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;

  // A write into a full FIFO still lands when a read frees the slot on the same edge.
  assign rd_acc  = rd_en && !empty;
  assign wr_acc  = wr_en && (!full || rd_acc);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_result_tx.sv
// Buffers result bytes and serialises them as 8N1 frames, LSB first, back to back with no idle gap.
module uart_result_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATA_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_result_tx_if.slave               res,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]        state;
  logic [15:0]       baud;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              pop;

  // Popping on the last STOP cycle is what makes consecutive frames contiguous.
  assign pop = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && baud == BAUD_LAST));
  assign tx_busy = (state != ST_IDLE) || !fifo_empty;
  assign res.fsm_state = state;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (res.res_valid),
    .wr_data (res.res_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (res.res_valid && fifo_full && !pop) overflow <= 1'b1;
  end

  // tx is loaded with the level of the state being entered, so it stays a clean register output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          baud <= '0;
          tx   <= 1'b1;
          if (pop) begin
            shift <= fifo_rd_data;
            state <= ST_START;
            tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
            tx      <= shift[0];
          end else begin
            baud <= baud + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (pop) begin
              shift <= fifo_rd_data;
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx: line-level reference model, per-cycle compare, line decoder.
module tb_uart_result_tx;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tx;
  logic          tx_busy;
  logic          fifo_full;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  uart_result_tx_if res_if ();

  uart_result_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .res        (res_if),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;
  int cyc      = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // fq holds accepted bytes; line_q holds the expected tx level for each upcoming cycle.
  logic [7:0] fq[$];
  logic       line_q[$];
  logic       m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    int         pre;
    bit         popped;
    logic [7:0] b;
    if (rst) begin
      fq.delete();
      line_q.delete();
      m_ovf = 1'b0;
    end else begin
      pre    = fq.size();
      popped = 1'b0;
      if (line_q.size() > 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && pre > 0) begin
        b      = fq.pop_front();
        popped = 1'b1;
        for (int i = 0; i < FRAME_BITS; i++)
          for (int c = 0; c < CPB; c++)
            line_q.push_back(i == 0 ? 1'b0 : (i == FRAME_BITS - 1 ? 1'b1 : b[i-1]));
      end
      if (res_if.res_valid) begin
        if (pre < DEPTH || popped) fq.push_back(res_if.res_data);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic exp_tx;
    if (check_en && !rst) begin
      exp_tx = (line_q.size() > 0) ? line_q[0] : 1'b1;
      chk("tx", 32'(tx), 32'(exp_tx));
      chk("tx_busy", 32'(tx_busy), 32'(line_q.size() > 0 || fq.size() > 0));
      chk("fifo_count", 32'(fifo_count), 32'(fq.size()));
      chk("fifo_full", 32'(fifo_full), 32'(fq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // ---------------- line decoder ----------------
  logic [7:0] rx_q[$];
  int         rx_start[$];

  always begin : rx_dec
    logic [7:0] d;
    int         st;
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      st = cyc;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        d[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      rx_q.push_back(d);
      rx_start.push_back(st);
      repeat (CPB - 2) @(negedge clk);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_seq(input logic [7:0] bytes[$], output int counts[$]);
    counts.delete();
    foreach (bytes[i]) begin
      res_if.res_valid = 1'b1;
      res_if.res_data  = bytes[i];
      @(negedge clk);
      counts.push_back(int'(fifo_count));
    end
    res_if.res_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 2000), 32'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_rx(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, 32'(rx_q.size()), 32'(exp.size()));
    foreach (exp[i]) chk(name, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    rx_q.delete();
    rx_start.delete();
  endtask

  task automatic chk_counts(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    foreach (exp[i]) chk(name, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b[$];
    logic [7:0] e[$];
    int         cnts[$];
    int         ec[$];
    res_if.res_valid = 1'b0;
    res_if.res_data  = 8'h00;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_state", 32'(res_if.fsm_state), 32'(ST_IDLE));
    rst      = 1'b0;
    check_en = 1'b1;

    // idle line
    repeat (1000) @(negedge clk);
    chk("idle_frames", 32'(rx_q.size()), 32'd0);

    // single byte, one-edge latency to start bit
    b = {8'hA5};
    send_seq(b, cnts);
    chk("single_cnt", 32'(cnts[0]), 32'd1);
    chk("single_tx_before_pop", 32'(tx), 32'd1);
    @(negedge clk);
    chk("single_tx_start", 32'(tx), 32'd0);
    chk("single_state", 32'(res_if.fsm_state), 32'(ST_START));
    wait_idle("single_drain");
    chk("single_ovf", 32'(overflow), 32'd0);
    e = {8'hA5};
    chk_rx("single_rx", e);

    // burst of three, contiguous frames
    b = {8'h02, 8'h01, 8'hFF};
    send_seq(b, cnts);
    ec = {1, 1, 2};
    chk_counts("burst_cnt", cnts, ec);
    wait_idle("burst_drain");
    chk("burst_count_end", 32'(fifo_count), 32'd0);
    chk("burst_gap1", (rx_start.size() >= 2) ? 32'(rx_start[1] - rx_start[0]) : 32'hFFFF_FFFF, 32'd40);
    chk("burst_gap2", (rx_start.size() >= 3) ? 32'(rx_start[2] - rx_start[1]) : 32'hFFFF_FFFF, 32'd40);
    e = {8'h02, 8'h01, 8'hFF};
    chk_rx("burst_rx", e);

    // full FIFO, write lands on the final STOP cycle
    b = {8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    send_seq(b, cnts);
    ec = {1, 1, 2, 3, 4};
    chk_counts("fp_cnt_seq", cnts, ec);
    chk("fp_full_before", 32'(fifo_full), 32'd1);
    repeat (36) @(negedge clk);
    chk("fp_state", 32'(res_if.fsm_state), 32'(ST_STOP));
    res_if.res_valid = 1'b1;
    res_if.res_data  = 8'h25;
    @(negedge clk);
    res_if.res_valid = 1'b0;
    chk("fp_count", 32'(fifo_count), 32'd4);
    chk("fp_ovf", 32'(overflow), 32'd0);
    wait_idle("fp_drain");
    e = {8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    chk_rx("fp_rx", e);

    // overflow: sixth back-to-back byte is dropped
    b = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    send_seq(b, cnts);
    ec = {1, 1, 2, 3, 4, 4};
    chk_counts("ovf_cnt_seq", cnts, ec);
    chk("ovf_set", 32'(overflow), 32'd1);
    wait_idle("ovf_drain");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    e = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    chk_rx("ovf_rx", e);

    // reset during data bit 3 of 8'h3C with two bytes queued
    b = {8'h3C, 8'h55, 8'h66};
    send_seq(b, cnts);
    repeat (16) @(negedge clk);
    chk("mid_state", 32'(res_if.fsm_state), 32'(ST_DATA));
    chk("mid_count", 32'(fifo_count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    rx_q.delete();
    rx_start.delete();
    repeat (100) @(negedge clk);
    chk("mid_no_frame", 32'(rx_q.size()), 32'd0);
    chk("mid_idle_tx", 32'(tx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, expected finish before %0t", $time);
    $fatal(1, "bench timeout");
  end
endmodule
